// File: rtl/memory_port_arbiter_if.sv
// memory_port_arbiter_if: bundles the three requester handshakes and the
// external memory port around memory_port_arbiter.
//   master modport - the arbiter's view (drives pulses, data and the port)
//   slave  modport - the environment's view (requesters and memory)
interface memory_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Instruction fetch requester
    logic                  fetch_enable;
    logic [ADDR_WIDTH-1:0] fetch_address;
    logic                  fetch_valid;
    logic [DATA_WIDTH-1:0] fetch_data;
    // Read-stage load requester
    logic                  address_enable;
    logic [ADDR_WIDTH-1:0] address;
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] data;
    // Write-stage store requester
    logic                  store_enable;
    logic [ADDR_WIDTH-1:0] store_address;
    logic [DATA_WIDTH-1:0] store_data;
    logic                  store_done;
    // External memory port
    logic                  mem_request;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_accept;
    logic                  mem_read_valid;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport master (
        input  fetch_enable, fetch_address,
        input  address_enable, address,
        input  store_enable, store_address, store_data,
        input  mem_accept, mem_read_valid, mem_read_data,
        output fetch_valid, fetch_data,
        output data_valid, data,
        output store_done,
        output mem_request, mem_write, mem_address, mem_write_data
    );

    modport slave (
        output fetch_enable, fetch_address,
        output address_enable, address,
        output store_enable, store_address, store_data,
        output mem_accept, mem_read_valid, mem_read_data,
        input  fetch_valid, fetch_data,
        input  data_valid, data,
        input  store_done,
        input  mem_request, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares the single external memory port between
// instruction fetch, the read-stage load and the write-stage store.
// Fixed priority store > load > fetch, one transaction outstanding.
// Optional feature macro: MEMORY_PORT_FETCH_GUARD_EN - adds a fetch
// starvation counter that forces fetch ahead after STARVE_LIMIT denials.
module memory_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    memory_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {GNT_FETCH, GNT_LOAD, GNT_STORE} grant_t;

    state_t                state_q;
    grant_t                grant_q;
    grant_t                grant_d;
    logic                  mem_write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] fetch_data_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic any_req;
    logic fetch_force;
    logic granted_en;
    logic fetch_hit;
    logic load_hit;

    assign any_req = bus.fetch_enable | bus.address_enable | bus.store_enable;

`ifdef MEMORY_PORT_FETCH_GUARD_EN
    logic [7:0] starve_q;

    assign fetch_force = bus.fetch_enable && (int'(starve_q) >= STARVE_LIMIT);

    // Count arbitrations fetch loses while waiting; saturate at 255.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= 8'd0;
        end else if (!bus.fetch_enable) begin
            starve_q <= 8'd0;
        end else if (state_q == IDLE) begin
            if (grant_d == GNT_FETCH) begin
                starve_q <= 8'd0;
            end else if (starve_q != 8'hFF) begin
                starve_q <= starve_q + 8'd1;
            end
        end
    end
`else
    logic [7:0] starve_limit_unused;

    assign starve_limit_unused = 8'(STARVE_LIMIT);
    assign fetch_force         = 1'b0;
`endif

    // Pick the winner among the live enables and its address.
    always_comb begin
        grant_d = GNT_FETCH;
        if (fetch_force) begin
            grant_d = GNT_FETCH;
        end else if (bus.store_enable) begin
            grant_d = GNT_STORE;
        end else if (bus.address_enable) begin
            grant_d = GNT_LOAD;
        end
        case (grant_d)
            GNT_STORE: addr_d = bus.store_address;
            GNT_LOAD:  addr_d = bus.address;
            default:   addr_d = bus.fetch_address;
        endcase
    end

    // Track whether the current owner still wants its transaction.
    always_comb begin
        case (grant_q)
            GNT_STORE: granted_en = bus.store_enable;
            GNT_LOAD:  granted_en = bus.address_enable;
            default:   granted_en = bus.fetch_enable;
        endcase
    end

    assign fetch_hit = (state_q == WAIT) && bus.mem_read_valid && granted_en
                       && (grant_q == GNT_FETCH);
    assign load_hit  = (state_q == WAIT) && bus.mem_read_valid && granted_en
                       && (grant_q == GNT_LOAD);

    // Transaction FSM: latch the grant in IDLE, hold it through ISSUE/WAIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= GNT_FETCH;
            mem_write_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            fetch_data_q <= '0;
            data_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q     <= grant_d;
                        addr_q      <= addr_d;
                        wdata_q     <= bus.store_data;
                        mem_write_q <= (grant_d == GNT_STORE);
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // An accept already committed the memory side, so it
                    // takes precedence over a same-cycle flush.
                    if (bus.mem_accept) begin
                        if (grant_q == GNT_STORE) begin
                            mem_write_q <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            state_q <= WAIT;
                        end
                    end else if (!granted_en) begin
                        mem_write_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                WAIT: begin
                    if (bus.mem_read_valid) begin
                        state_q <= IDLE;
                    end
                    if (fetch_hit) begin
                        fetch_data_q <= bus.mem_read_data;
                    end
                    if (load_hit) begin
                        data_q <= bus.mem_read_data;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Port drive comes straight from the latched registers.
    assign bus.mem_request    = (state_q == ISSUE);
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = wdata_q;

    // Responses: read data bypasses to the owner in the return cycle,
    // everyone else holds the last word they received.
    assign bus.store_done  = (state_q == ISSUE) && bus.mem_accept
                             && (grant_q == GNT_STORE);
    assign bus.fetch_valid = fetch_hit;
    assign bus.fetch_data  = fetch_hit ? bus.mem_read_data : fetch_data_q;
    assign bus.data_valid  = load_hit;
    assign bus.data        = load_hit ? bus.mem_read_data : data_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed testbench for memory_port_arbiter (STARVE_LIMIT = 2). Honours
// MEMORY_PORT_FETCH_GUARD_EN for the starvation scenario.
module tb_memory_port_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    memory_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    memory_port_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .STARVE_LIMIT(2)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.fetch_enable   = 1'b0; bus.fetch_address = '0;
        bus.address_enable = 1'b0; bus.address       = '0;
        bus.store_enable   = 1'b0; bus.store_address = '0; bus.store_data = '0;
        bus.mem_accept     = 1'b0; bus.mem_read_valid = 1'b0; bus.mem_read_data = '0;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.mem_request, bus.mem_write, bus.fetch_valid, bus.data_valid, bus.store_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {bus.mem_request, bus.mem_write, bus.fetch_valid, bus.data_valid, bus.store_done});
        end
        checks++;
        if ({bus.mem_address, bus.mem_write_data, bus.fetch_data, bus.data} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0",
                     {bus.mem_address, bus.mem_write_data, bus.fetch_data, bus.data});
        end
    endtask

    task automatic test_fetch();
        bus.fetch_enable = 1'b1; bus.fetch_address = 32'h100;
        #1;
        checks++;
        if (bus.mem_request !== 1'b0) begin
            errors++; $display("FAIL fetch_req_T: got %b expected 0", bus.mem_request);
        end
        cyc();
        checks++;
        if ({bus.mem_request, bus.mem_write, bus.mem_address} !== {1'b1, 1'b0, 32'h100}) begin
            errors++; $display("FAIL fetch_issue: got req=%b wr=%b addr=%h expected 1 0 00000100",
                               bus.mem_request, bus.mem_write, bus.mem_address);
        end
        bus.mem_accept = 1'b1;
        cyc();
        bus.mem_accept = 1'b0;
        bus.mem_read_valid = 1'b1; bus.mem_read_data = 32'hDEADBEEF;
        #1;
        checks++;
        if ({bus.fetch_valid, bus.fetch_data, bus.mem_request, bus.mem_write} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0}) begin
            errors++; $display("FAIL fetch_return: got v=%b d=%h req=%b wr=%b expected 1 deadbeef 0 0",
                               bus.fetch_valid, bus.fetch_data, bus.mem_request, bus.mem_write);
        end
        cyc();
        bus.fetch_enable = 1'b0; bus.mem_read_valid = 1'b0; bus.mem_read_data = 32'h0;
        #1;
        checks++;
        if ({bus.fetch_valid, bus.fetch_data, bus.mem_request} !== {1'b0, 32'hDEADBEEF, 1'b0}) begin
            errors++; $display("FAIL fetch_after: got v=%b d=%h req=%b expected 0 deadbeef 0",
                               bus.fetch_valid, bus.fetch_data, bus.mem_request);
        end
    endtask

    task automatic test_store_load();
        bus.store_enable = 1'b1; bus.store_address = 32'h20; bus.store_data = 32'h55;
        bus.address_enable = 1'b1; bus.address = 32'h40;
        cyc();
        bus.mem_accept = 1'b1;
        #1;
        checks++;
        if ({bus.mem_request, bus.mem_write, bus.mem_address, bus.mem_write_data} !== {1'b1, 1'b1, 32'h20, 32'h55}) begin
            errors++; $display("FAIL store_issue: got req=%b wr=%b a=%h d=%h expected 1 1 00000020 00000055",
                               bus.mem_request, bus.mem_write, bus.mem_address, bus.mem_write_data);
        end
        checks++;
        if ({bus.store_done, bus.data_valid} !== 2'b10) begin
            errors++; $display("FAIL store_done: got %b expected 10", {bus.store_done, bus.data_valid});
        end
        cyc();
        bus.store_enable = 1'b0; bus.mem_accept = 1'b0;
        #1;
        checks++;
        if ({bus.mem_request, bus.store_done} !== 2'b00) begin
            errors++; $display("FAIL store_idle: got %b expected 00", {bus.mem_request, bus.store_done});
        end
        cyc();
        bus.mem_accept = 1'b1;
        #1;
        checks++;
        if ({bus.mem_request, bus.mem_write, bus.mem_address} !== {1'b1, 1'b0, 32'h40}) begin
            errors++; $display("FAIL load_issue: got req=%b wr=%b a=%h expected 1 0 00000040",
                               bus.mem_request, bus.mem_write, bus.mem_address);
        end
        cyc();
        bus.mem_accept = 1'b0;
        #1;
        checks++;
        if (bus.data_valid !== 1'b0) begin
            errors++; $display("FAIL load_early: got %b expected 0", bus.data_valid);
        end
        cyc();
        bus.mem_read_valid = 1'b1; bus.mem_read_data = 32'h12345678;
        #1;
        checks++;
        if ({bus.data_valid, bus.data, bus.fetch_valid, bus.fetch_data} !== {1'b1, 32'h12345678, 1'b0, 32'hDEADBEEF}) begin
            errors++; $display("FAIL load_return: got v=%b d=%h fv=%b fd=%h expected 1 12345678 0 deadbeef",
                               bus.data_valid, bus.data, bus.fetch_valid, bus.fetch_data);
        end
        cyc();
        bus.address_enable = 1'b0; bus.mem_read_valid = 1'b0;
        #1;
        checks++;
        if ({bus.data_valid, bus.data} !== {1'b0, 32'h12345678}) begin
            errors++; $display("FAIL load_hold: got v=%b d=%h expected 0 12345678", bus.data_valid, bus.data);
        end
    endtask

    task automatic test_delayed_accept();
        bus.address_enable = 1'b1; bus.address = 32'h80;
        cyc();
        bus.address = 32'hFFF;
        for (int i = 0; i < 4; i++) begin
            bus.mem_accept = (i == 3);
            #1;
            checks++;
            if ({bus.mem_request, bus.mem_address} !== {1'b1, 32'h80}) begin
                errors++; $display("FAIL delay_hold%0d: got req=%b a=%h expected 1 00000080",
                                   i, bus.mem_request, bus.mem_address);
            end
            cyc();
        end
        bus.mem_accept = 1'b0;
        bus.mem_read_valid = 1'b1; bus.mem_read_data = 32'hA5A5A5A5;
        #1;
        checks++;
        if ({bus.mem_request, bus.data_valid, bus.data} !== {1'b0, 1'b1, 32'hA5A5A5A5}) begin
            errors++; $display("FAIL delay_wait: got req=%b v=%b d=%h expected 0 1 a5a5a5a5",
                               bus.mem_request, bus.data_valid, bus.data);
        end
        cyc();
        bus.address_enable = 1'b0; bus.mem_read_valid = 1'b0;
    endtask

    task automatic test_flush();
        // Drop during ISSUE
        bus.fetch_enable = 1'b1; bus.fetch_address = 32'h200;
        cyc();
        bus.fetch_enable = 1'b0;
        cyc();
        #1;
        checks++;
        if ({bus.mem_request, bus.fetch_valid} !== 2'b00) begin
            errors++; $display("FAIL flush_issue: got %b expected 00", {bus.mem_request, bus.fetch_valid});
        end
        // Drop during WAIT
        bus.fetch_enable = 1'b1; bus.fetch_address = 32'h300;
        cyc();
        bus.mem_accept = 1'b1;
        cyc();
        bus.mem_accept = 1'b0; bus.fetch_enable = 1'b0;
        cyc();
        bus.mem_read_valid = 1'b1; bus.mem_read_data = 32'h77;
        #1;
        checks++;
        if ({bus.fetch_valid, bus.fetch_data} !== {1'b0, 32'hDEADBEEF}) begin
            errors++; $display("FAIL flush_wait: got v=%b d=%h expected 0 deadbeef", bus.fetch_valid, bus.fetch_data);
        end
        cyc();
        bus.mem_read_valid = 1'b0;
        bus.address_enable = 1'b1; bus.address = 32'h44;
        cyc();
        checks++;
        if ({bus.mem_request, bus.mem_address} !== {1'b1, 32'h44}) begin
            errors++; $display("FAIL flush_recover: got req=%b a=%h expected 1 00000044",
                               bus.mem_request, bus.mem_address);
        end
        bus.address_enable = 1'b0;
        cyc();
    endtask

    task automatic test_starvation();
        logic [31:0] exp_addr;
        logic        exp_fetch;
        bus.fetch_enable = 1'b1;   bus.fetch_address = 32'h500;
        bus.address_enable = 1'b1; bus.address       = 32'h600;
        for (int k = 1; k <= 4; k++) begin
`ifdef MEMORY_PORT_FETCH_GUARD_EN
            exp_fetch = (k == 3);
`else
            exp_fetch = 1'b0;
`endif
            exp_addr = exp_fetch ? 32'h500 : 32'h600;
            cyc();
            bus.mem_accept = 1'b1;
            #1;
            checks++;
            if ({bus.mem_request, bus.mem_address} !== {1'b1, exp_addr}) begin
                errors++; $display("FAIL starve_arb%0d: got req=%b a=%h expected 1 %h",
                                   k, bus.mem_request, bus.mem_address, exp_addr);
            end
            cyc();
            bus.mem_accept = 1'b0;
            bus.mem_read_valid = 1'b1; bus.mem_read_data = 32'(k);
            #1;
            checks++;
            if ({bus.fetch_valid, bus.data_valid} !== {exp_fetch, ~exp_fetch}) begin
                errors++; $display("FAIL starve_pulse%0d: got fv=%b dv=%b expected %b %b",
                                   k, bus.fetch_valid, bus.data_valid, exp_fetch, ~exp_fetch);
            end
            cyc();
            bus.mem_read_valid = 1'b0;
        end
        bus.fetch_enable = 1'b0; bus.address_enable = 1'b0;
        cyc();
    endtask

    task automatic test_reset_wait();
        bus.address_enable = 1'b1; bus.address = 32'h90;
        cyc();
        bus.mem_accept = 1'b1;
        cyc();
        bus.mem_accept = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0; bus.address_enable = 1'b0;
        #1;
        checks++;
        if ({bus.mem_request, bus.mem_write, bus.mem_address, bus.fetch_data, bus.data} !== {2'b00, 96'h0}) begin
            errors++; $display("FAIL rstwait_out: got req=%b wr=%b a=%h fd=%h d=%h expected all 0",
                               bus.mem_request, bus.mem_write, bus.mem_address, bus.fetch_data, bus.data);
        end
        bus.mem_read_valid = 1'b1; bus.mem_read_data = 32'hBAD;
        #1;
        checks++;
        if ({bus.data_valid, bus.fetch_valid, bus.data} !== {2'b00, 32'h0}) begin
            errors++; $display("FAIL rstwait_late: got dv=%b fv=%b d=%h expected 0 0 0",
                               bus.data_valid, bus.fetch_valid, bus.data);
        end
        cyc();
        bus.mem_read_valid = 1'b0;
        #1;
        checks++;
        if (bus.mem_request !== 1'b0) begin
            errors++; $display("FAIL rstwait_idle: got %b expected 0", bus.mem_request);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fetch();
        test_store_load();
        test_delayed_accept();
        test_flush();
        test_starvation();
        test_reset_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
